// File: rtl/route_loop_checker.sv
// Pattern source/sink for routed SLICE feedback loops: drives an LFSR pattern out,
// compares the returned nets after LAT cycles, and reports a verdict plus error stats.
//
// state | meaning
// IDLE  | waiting for start, pat_out held at 0
// RUN   | issuing TEST_LEN patterns, comparing returns as they arrive
// DRAIN | pattern stopped, collecting the last LAT returns
// DONE  | verdict valid, waiting for the next start
module route_loop_checker #(
  parameter int LANES    = 4,
  parameter int LAT      = 1,
  parameter int TEST_LEN = 256,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [LANES-1:0] pat_out,
  input  logic [LANES-1:0] pat_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [LANES-1:0] err_lanes
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] RUN_END   = 16'(TEST_LEN - 1);
  localparam logic [15:0] DRAIN_END = 16'(LAT - 1);

  state_t           state, state_nxt;
  logic [15:0]      lfsr;
  logic [15:0]      cnt;
  logic [LANES:0]   dly [LAT];
  logic [LANES-1:0] mism;
  logic             go;
  logic             run_last;
  logic             drain_last;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign go         = start && (state == IDLE || state == DONE);
  assign run_last   = (cnt == RUN_END);
  assign drain_last = (cnt == DRAIN_END);
  assign mism       = pat_in ^ dly[LAT-1][LANES-1:0];

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // lfsr always holds the pattern that pat_out will take on the next RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      cnt       <= '0;
      pat_out   <= '0;
      err_count <= '0;
      err_lanes <= '0;
      for (int i = 0; i < LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {state == RUN, pat_out};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];

      if (go) begin
        lfsr      <= lfsr_step(SEED);
        pat_out   <= SEED[LANES-1:0];
        cnt       <= '0;
        err_count <= '0;
        err_lanes <= '0;
      end else begin
        if (dly[LAT-1][LANES]) begin
          err_lanes <= err_lanes | mism;
          if (mism != '0 && err_count != '1) err_count <= err_count + ERR_W'(1);
        end
        case (state)
          RUN: begin
            if (run_last) begin
              pat_out <= '0;
              cnt     <= '0;
            end else begin
              pat_out <= lfsr[LANES-1:0];
              lfsr    <= lfsr_step(lfsr);
              cnt     <= cnt + 16'd1;
            end
          end
          DRAIN:   cnt <= cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_route_loop_checker.sv
// Bench for route_loop_checker: two instances (LAT=1/ERR_W=16 and LAT=2/ERR_W=3) with
// configurable loop models, checked every cycle against a run-timeline model.
module tb_route_loop_checker;

  localparam int TL = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pat_out0, pat_out1, pat_in0, pat_in1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] err_count0;
  logic [2:0]  err_count1;
  logic [3:0]  err_lanes0, err_lanes1;

  // Loop models: 1- or 2-cycle delay, with stuck-at-0 mask, inversion mask and noise.
  logic [3:0] lpa [2];
  logic [3:0] lpb [2];
  logic [3:0] andm [2];
  logic [3:0] xorm [2];
  logic [3:0] noise [2];
  int         dep [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  // Reference model: cycles since the start edge per instance.
  logic [3:0] pats [TL];
  bit         m_idle [2];
  int         m_t [2];
  int         m_err [2];
  logic [3:0] m_lanes [2];

  always #5 clk = ~clk;

  route_loop_checker #(.LANES(4), .LAT(1), .TEST_LEN(TL), .ERR_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_out0), .pat_in(pat_in0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0), .err_lanes(err_lanes0)
  );

  route_loop_checker #(.LANES(4), .LAT(2), .TEST_LEN(TL), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_out1), .pat_in(pat_in1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .err_lanes(err_lanes1)
  );

  assign pat_in0 = ((dep[0] == 2 ? lpb[0] : lpa[0]) & andm[0]) ^ xorm[0] ^ noise[0];
  assign pat_in1 = ((dep[1] == 2 ? lpb[1] : lpa[1]) & andm[1]) ^ xorm[1] ^ noise[1];

  always @(posedge clk) begin
    lpa[0] <= pat_out0;
    lpb[0] <= lpa[0];
    lpa[1] <= pat_out1;
    lpb[1] <= lpa[1];
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int max_of(input int i);
    return (i == 0) ? 65535 : 7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < TL; k++) begin
      pats[k] = l[3:0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1; m_t[i] = 0; m_err[i] = 0; m_lanes[i] = '0;
    end
  end

  // Model update: compare step of the current cycle, then the start/reset decision.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] pin, mm;
      int         k;
      pin = (i == 0) ? pat_in0 : pat_in1;
      k = m_t[i] - lat_of(i);
      if (!m_idle[i] && k >= 1 && k <= TL) begin
        mm = pin ^ pats[k-1];
        m_lanes[i] = m_lanes[i] | mm;
        if (mm != 0 && m_err[i] < max_of(i)) m_err[i]++;
      end
      if (rst) begin
        m_idle[i] = 1; m_t[i] = 0; m_err[i] = 0; m_lanes[i] = '0;
      end else if (start && (m_idle[i] || m_t[i] > TL + lat_of(i))) begin
        m_idle[i] = 0; m_t[i] = 1; m_err[i] = 0; m_lanes[i] = '0;
      end else if (!m_idle[i] && m_t[i] < 10000) begin
        m_t[i]++;
      end
    end
  end

  task automatic check_inst(input int i, input logic [3:0] po, input logic b, input logic d,
                            input logic p, input logic [31:0] ec, input logic [3:0] el);
    logic [3:0] e_po;
    logic       e_b, e_d;
    int         t;
    t = m_t[i];
    e_po = '0; e_b = 0; e_d = 0;
    if (!m_idle[i]) begin
      if (t >= 1 && t <= TL) begin
        e_po = pats[t-1]; e_b = 1;
      end else if (t > TL && t <= TL + lat_of(i)) begin
        e_b = 1;
      end else begin
        e_d = 1;
      end
    end
    chk($sformatf("pat_out%0d", i), po, e_po);
    chk($sformatf("busy%0d", i), b, e_b);
    chk($sformatf("done%0d", i), d, e_d);
    chk($sformatf("pass%0d", i), p, e_d && m_err[i] == 0);
    chk($sformatf("err_count%0d", i), ec, m_err[i]);
    chk($sformatf("err_lanes%0d", i), el, m_lanes[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, pat_out0, busy0, done0, pass0, 32'(err_count0), err_lanes0);
      check_inst(1, pat_out1, busy1, done1, pass1, 32'(err_count1), err_lanes1);
    end
  end

  task automatic set_ideal();
    for (int i = 0; i < 2; i++) begin
      andm[i] = 4'hF; xorm[i] = 4'h0; noise[i] = 4'h0; dep[i] = 1;
    end
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    int n_bit2;
    bit noise_en [2];
    rst = 1; start = 0;
    set_ideal();
    step();
    step();
    chk_en = 1;
    rst = 0;
    chk("rst_pat_out", pat_out0, 4'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_err_count", err_count0, 16'h0);
    chk("rst_err_lanes", err_lanes0, 4'h0);
    step();

    // Ideal loop on dut0; latency mismatch on dut1 (LAT=2 vs 1-cycle loop).
    pulse_start();
    chk("pat0", pat_out0, 4'h1);
    step();
    chk("pat1", pat_out0, 4'h3);
    step();
    chk("pat2", pat_out0, 4'h7);
    chk("model_pat2", pats[2], 4'h7);
    repeat (14) step();
    chk("c17_done0", done0, 1'b0);
    chk("c17_busy0", busy0, 1'b1);
    step();
    chk("c18_done0", done0, 1'b1);
    chk("c18_pass0", pass0, 1'b1);
    chk("c18_err0", err_count0, 16'h0);
    chk("c18_lanes0", err_lanes0, 4'b0000);
    chk("c18_done1", done1, 1'b0);
    step();
    chk("lat_done1", done1, 1'b1);
    chk("lat_pass1", pass1, 1'b0);
    chk("lat_err_nz", err_count1 != 3'd0, 1'b1);

    // Stuck lane 2 on dut0; inverted 2-cycle loop saturates dut1's 3-bit counter.
    andm[0] = 4'b1011;
    dep[1] = 2; xorm[1] = 4'hF;
    n_bit2 = 0;
    for (int k = 0; k < TL; k++) if (pats[k][2]) n_bit2++;
    pulse_start();
    chk("b2b_done_drop", done0, 1'b0);
    repeat (17) step();
    chk("stuck_lanes", err_lanes0, 4'b0100);
    chk("stuck_count", err_count0, n_bit2);
    chk("stuck_pass", pass0, 1'b0);
    step();
    chk("sat_count", err_count1, 3'b111);
    chk("sat_lanes", err_lanes1, 4'b1111);

    // Start pulsed while busy must not restart the run.
    set_ideal();
    pulse_start();
    repeat (4) step();
    pulse_start();
    repeat (11) step();
    chk("busy_start_c17", done0, 1'b0);
    step();
    chk("busy_start_done", done0, 1'b1);
    chk("busy_start_pass", pass0, 1'b1);
    step();

    // Reset at cycle 8 of RUN, with start also high: reset wins.
    andm[0] = 4'b1011;
    pulse_start();
    repeat (7) step();
    rst = 1; start = 1;
    step();
    rst = 0; start = 0;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_pat", pat_out0, 4'h0);
    chk("mid_rst_err", err_count0, 16'h0);
    set_ideal();
    step();
    pulse_start();
    chk("post_rst_pat0", pat_out0, 4'h1);
    repeat (17) step();
    chk("post_rst_pass", pass0, 1'b1);

    // Randomized phase: random loop faults, noise, starts and occasional resets.
    noise_en[0] = 0; noise_en[1] = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        for (int i = 0; i < 2; i++) begin
          dep[i]  = $urandom_range(1, 2);
          andm[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
          xorm[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
          noise_en[i] = ($urandom_range(0, 1) == 1);
        end
      end
      for (int i = 0; i < 2; i++)
        noise[i] = (noise_en[i] && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      start = ($urandom_range(0, 14) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 0; start = 0;
    set_ideal();
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
